// File: rtl/connect_pkg.sv
// connect_pkg: shared cell codes, FSM state type and grid indexing for the Connect Four AI
package connect_pkg;
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    typedef enum logic [2:0] {
        IDLE, AI_SETUP, SLOT_PRESENT, SLOT_CAPTURE, COMPARE, DONE
    } fsm_state_t;

    // LSB of cell (r,c); row 0 is the bottom, column 0 sits in the top bits of each row
    function automatic int cell_bit(input int r, input int c, input int ncols = 7);
        return 2 * ncols * r + 2 * (ncols - 1 - c);
    endfunction
endpackage

// File: rtl/connect_score.sv
// connect_score: registered heuristic score of a board from the AI's point of view
//   clk     in   rising-edge clock
//   grid    in   2*NUM_ROWS*NUM_COLS board, cell (r,c) at cell_bit(r,c)
//   ai_code in   2  cell code of the AI piece; any other non-empty code is the opponent
//   score   out  SCORE_W, one cycle after grid: 0 = opponent has four, all ones = AI has four,
//                otherwise midpoint + (AI-only windows) - (opponent-only windows)
module connect_score
    import connect_pkg::*;
#(
    parameter int NUM_ROWS = 6,
    parameter int NUM_COLS = 7,
    parameter int SCORE_W  = 9
) (
    input  logic                           clk,
    input  logic [2*NUM_ROWS*NUM_COLS-1:0] grid,
    input  logic [1:0]                     ai_code,
    output logic [SCORE_W-1:0]             score
);
    localparam int MID = 1 << (SCORE_W - 1);

    logic [SCORE_W-1:0] score_d, score_q;
    logic [1:0]         v;
    logic               ai4, op4;
    int                 ai_n, op_n, na, no;

    // window directions: 0 horizontal, 1 vertical, 2 rising diagonal, 3 falling diagonal
    function automatic int dr(input int d);
        return (d == 0) ? 0 : 1;
    endfunction

    function automatic int dc(input int d);
        return (d == 1) ? 0 : (d == 3) ? -1 : 1;
    endfunction

    always_comb begin
        ai_n = 0;
        op_n = 0;
        na   = 0;
        no   = 0;
        v    = CELL_EMPTY;
        ai4  = 1'b0;
        op4  = 1'b0;
        for (int d = 0; d < 4; d++)
            for (int r = 0; r < NUM_ROWS; r++)
                for (int c = 0; c < NUM_COLS; c++)
                    if (r + 3 * dr(d) < NUM_ROWS && c + 3 * dc(d) >= 0 && c + 3 * dc(d) < NUM_COLS) begin
                        na = 0;
                        no = 0;
                        for (int i = 0; i < 4; i++) begin
                            v = grid[cell_bit(r + i * dr(d), c + i * dc(d), NUM_COLS) +: 2];
                            if (v == ai_code) na = na + 1;
                            else if (v != CELL_EMPTY) no = no + 1;
                        end
                        if (na == 4) ai4 = 1'b1;
                        if (no == 4) op4 = 1'b1;
                        if (na > 0 && no == 0) ai_n = ai_n + 1;
                        if (no > 0 && na == 0) op_n = op_n + 1;
                    end
        score_d = op4 ? '0 : ai4 ? '1 : SCORE_W'(MID + ai_n - op_n);
    end

    always_ff @(posedge clk) score_q <= score_d;

    assign score = score_q;
endmodule

// File: rtl/minimax_col_select.sv
// minimax_col_select: 2-ply (or greedy 1-ply) minimax column chooser for the Connect Four AI
//   clk, rst       clock, synchronous active-high reset
//   start          begin an evaluation (accepted only when idle)
//   greedy         1 = score AI drops only, 0 = worst case over opponent replies
//   ai_code        AI cell code, opponent is its complement
//   grid           board snapshot source, column_counts = pieces per column
//   busy           evaluation in progress (through the done cycle)
//   done           one-cycle pulse, best_* valid from this cycle until the next done
//   best_col       chosen column, best_valid = some legal move existed, best_score = its score
module minimax_col_select
    import connect_pkg::*;
#(
    parameter int NUM_COLS = 7,
    parameter int NUM_ROWS = 6,
    parameter int CNT_W    = 3,
    parameter int SCORE_W  = 9
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           greedy,
    input  logic [1:0]                     ai_code,
    input  logic [2*NUM_ROWS*NUM_COLS-1:0] grid,
    input  logic [CNT_W*NUM_COLS-1:0]      column_counts,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(NUM_COLS)-1:0]    best_col,
    output logic                           best_valid,
    output logic [SCORE_W-1:0]             best_score
);
    localparam int GW = 2 * NUM_ROWS * NUM_COLS;
    localparam int CW = $clog2(NUM_COLS + 1);
    localparam int BW = $clog2(NUM_COLS);
    localparam logic [CW-1:0]    LAST_COL = CW'(NUM_COLS - 1);
    localparam logic [CNT_W-1:0] ROWS_C   = CNT_W'(NUM_ROWS);
    localparam logic [CNT_W-1:0] ROWS_M1  = CNT_W'(NUM_ROWS - 1);

    fsm_state_t                state_d, state_q;
    logic [GW-1:0]             grid_d, grid_q, board;
    logic [CNT_W*NUM_COLS-1:0] cnt_d, cnt_q;
    logic                      greedy_d, greedy_q;
    logic [1:0]                ai_code_d, ai_code_q;
    logic [CW-1:0]             ai_col_d, ai_col_q, opp_col_d, opp_col_q, last_slot;
    logic [SCORE_W-1:0]        aio_d, aio_q, min_d, min_q, run_best_d, run_best_q;
    logic [SCORE_W-1:0]        best_score_d, best_score_q, score, col_score;
    logic [BW-1:0]             run_col_d, run_col_q, best_col_d, best_col_q;
    logic                      any_d, any_q, found_d, found_q, best_valid_d, best_valid_q;
    logic [CNT_W-1:0]          ai_cnt, opp_cnt, opp_row;
    logic                      same, ai_ok, opp_ok, opp_on, take;

    connect_score #(.NUM_ROWS(NUM_ROWS), .NUM_COLS(NUM_COLS), .SCORE_W(SCORE_W)) u_score (
        .clk    (clk),
        .grid   (board),
        .ai_code(ai_code_q),
        .score  (score)
    );

    assign ai_cnt    = CNT_W'(cnt_q >> (CNT_W * int'(ai_col_q)));
    assign opp_cnt   = CNT_W'(cnt_q >> (CNT_W * int'(opp_col_q)));
    assign same      = opp_col_q == ai_col_q;
    assign ai_ok     = ai_cnt < ROWS_C;
    // a reply in the AI's own column lands on top of the AI piece
    assign opp_ok    = ai_ok && !greedy_q && (same ? ai_cnt < ROWS_M1 : opp_cnt < ROWS_C);
    assign opp_row   = same ? ai_cnt + 1'b1 : opp_cnt;
    assign opp_on    = state_q == SLOT_PRESENT && opp_ok;
    assign last_slot = greedy_q ? '0 : LAST_COL;
    assign col_score = any_q ? min_q : aio_q;
    assign take      = ai_ok && (!found_q || col_score > run_best_q);

    // AI_SETUP presents the AI-only board; SLOT_PRESENT adds the opponent reply when legal
    always_comb begin
        board = grid_q;
        for (int r = 0; r < NUM_ROWS; r++)
            for (int c = 0; c < NUM_COLS; c++) begin
                if (ai_ok && ai_col_q == CW'(c) && ai_cnt == CNT_W'(r))
                    board[cell_bit(r, c, NUM_COLS) +: 2] = ai_code_q;
                if (opp_on && opp_col_q == CW'(c) && opp_row == CNT_W'(r))
                    board[cell_bit(r, c, NUM_COLS) +: 2] = ~ai_code_q;
            end
    end

    always_comb begin
        state_d      = state_q;
        grid_d       = grid_q;
        cnt_d        = cnt_q;
        greedy_d     = greedy_q;
        ai_code_d    = ai_code_q;
        ai_col_d     = ai_col_q;
        opp_col_d    = opp_col_q;
        aio_d        = aio_q;
        min_d        = min_q;
        any_d        = any_q;
        run_best_d   = run_best_q;
        run_col_d    = run_col_q;
        found_d      = found_q;
        best_col_d   = best_col_q;
        best_valid_d = best_valid_q;
        best_score_d = best_score_q;
        case (state_q)
            IDLE: if (start) begin
                state_d    = AI_SETUP;
                grid_d     = grid;
                cnt_d      = column_counts;
                greedy_d   = greedy;
                ai_code_d  = (ai_code == CELL_P1) ? CELL_P1 : CELL_P2;
                ai_col_d   = '0;
                run_best_d = '0;
                run_col_d  = '0;
                found_d    = 1'b0;
            end
            AI_SETUP: begin
                state_d   = SLOT_PRESENT;
                opp_col_d = '0;
                any_d     = 1'b0;
                min_d     = '1;
            end
            SLOT_PRESENT: begin
                // the AI-only board score emerges during the first slot
                if (opp_col_q == '0) aio_d = score;
                state_d = SLOT_CAPTURE;
            end
            SLOT_CAPTURE: begin
                if (opp_ok) begin
                    any_d = 1'b1;
                    if (score < min_q) min_d = score;
                end
                if (opp_col_q == last_slot) state_d = COMPARE;
                else begin
                    opp_col_d = opp_col_q + 1'b1;
                    state_d   = SLOT_PRESENT;
                end
            end
            COMPARE: begin
                if (take) begin
                    run_best_d = col_score;
                    run_col_d  = BW'(ai_col_q);
                    found_d    = 1'b1;
                end
                if (ai_col_q == LAST_COL) begin
                    state_d      = DONE;
                    best_col_d   = take ? BW'(ai_col_q) : run_col_q;
                    best_score_d = take ? col_score : run_best_q;
                    best_valid_d = found_q || take;
                end else begin
                    ai_col_d = ai_col_q + 1'b1;
                    state_d  = AI_SETUP;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            best_col_q   <= '0;
            best_valid_q <= 1'b0;
            best_score_q <= '0;
        end else begin
            state_q      <= state_d;
            best_col_q   <= best_col_d;
            best_valid_q <= best_valid_d;
            best_score_q <= best_score_d;
        end
        grid_q     <= grid_d;
        cnt_q      <= cnt_d;
        greedy_q   <= greedy_d;
        ai_code_q  <= ai_code_d;
        ai_col_q   <= ai_col_d;
        opp_col_q  <= opp_col_d;
        aio_q      <= aio_d;
        min_q      <= min_d;
        any_q      <= any_d;
        run_best_q <= run_best_d;
        run_col_q  <= run_col_d;
        found_q    <= found_d;
    end

    assign busy       = state_q != IDLE;
    assign done       = state_q == DONE;
    assign best_col   = best_col_q;
    assign best_valid = best_valid_q;
    assign best_score = best_score_q;
endmodule
